// File: rtl/pooling_stream_mc.sv
// pooling_stream_mc: streaming multi-channel POOL_SIZE x POOL_SIZE pooling.
//
// Raster-ordered pixels (all channels packed) enter over a valid/ready
// handshake. Pooled pixels leave one cycle after the beat that completes
// their window. Pool mode (0 MAX, 1 AVG, 2 MIN, 3 zeros) is latched on
// the first beat of each frame. Pixels outside the covered floor area
// (col >= OUT_W*P or row >= OUT_H*P) are consumed and dropped.
//
// Optional feature: define POOL_ROUND_EN to make AVG round half up
// (saturating) instead of truncating.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pool_mode           pooling mode, sampled on first beat of a frame
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   in_data             pixel, channel c at [c*ELEM_WIDTH +: ELEM_WIDTH]
//   out_valid/out_ready output handshake
//   out_data            pooled pixel, same packing
//   out_last            marks the final pooled pixel of the frame
module pooling_stream_mc #(
  parameter int ELEM_WIDTH = 8,
  parameter int CHANNELS   = 4,
  parameter int POOL_SIZE  = 2,
  parameter int IMG_HEIGHT = 28,
  parameter int IMG_WIDTH  = 28
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [1:0]                     pool_mode,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*ELEM_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*ELEM_WIDTH-1:0] out_data,
  output logic                           out_last
);

  localparam int OUT_H = IMG_HEIGHT / POOL_SIZE;
  localparam int OUT_W = IMG_WIDTH / POOL_SIZE;
  localparam int P2    = POOL_SIZE * POOL_SIZE;
  localparam int ACC_W = ELEM_WIDTH + $clog2(P2);
  localparam int DW    = CHANNELS * ELEM_WIDTH;
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int PW    = $clog2(POOL_SIZE);
  localparam int WC_W  = $clog2(OUT_W + 1);
  localparam int WI_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_WLAST = COL_W'(OUT_W * POOL_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_WLAST = ROW_W'(OUT_H * POOL_SIZE - 1);
  localparam logic [COL_W:0]   COL_COVER = (COL_W + 1)'(OUT_W * POOL_SIZE);
  localparam logic [ROW_W:0]   ROW_COVER = (ROW_W + 1)'(OUT_H * POOL_SIZE);
  localparam logic [PW-1:0]    P_LAST    = PW'(POOL_SIZE - 1);

  localparam logic [1:0] MODE_MAX = 2'd0;
  localparam logic [1:0] MODE_AVG = 2'd1;
  localparam logic [1:0] MODE_MIN = 2'd2;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  // AVG result from a window sum; rounding variant saturates to the element range.
  function automatic logic [ELEM_WIDTH-1:0] avg_of(input logic [ACC_W-1:0] sum);
    logic [ACC_W:0] quo;
`ifdef POOL_ROUND_EN
    quo = ({1'b0, sum} + (ACC_W + 1)'(P2 / 2)) / (ACC_W + 1)'(P2);
`else
    quo = {1'b0, sum} / (ACC_W + 1)'(P2);
`endif
    if (quo > {{(ACC_W + 1 - ELEM_WIDTH){1'b0}}, {ELEM_WIDTH{1'b1}}}) begin
      avg_of = {ELEM_WIDTH{1'b1}};
    end else begin
      avg_of = quo[ELEM_WIDTH-1:0];
    end
  endfunction

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [PW-1:0]       px_q, px_d;   // column position inside the window
  logic [PW-1:0]       py_q, py_d;   // row position inside the window
  logic [WC_W-1:0]     wc_q, wc_d;   // window column index (col / POOL_SIZE)
  logic                out_valid_q, out_valid_d;
  logic [DW-1:0]       out_data_q, out_data_d;
  logic                out_last_q, out_last_d;

  logic [ACC_W-1:0]    acc_q [OUT_W][CHANNELS];
  logic [ACC_W-1:0]    acc_new_s [CHANNELS];
  logic [DW-1:0]       res_s;
  logic [1:0]          cur_mode_s;
  logic [WI_W-1:0]     wi_s;
  logic                accept_s, cover_s, first_s, complete_s, last_win_s;
  logic                end_row_s, end_frame_s;

  assign in_ready    = !out_valid_q || out_ready;
  assign accept_s    = in_valid && in_ready;
  // The first beat of a frame uses the live mode; later beats the latched one.
  assign cur_mode_s  = (state_q == ST_IDLE) ? pool_mode : mode_q;
  assign wi_s        = WI_W'(wc_q);
  assign cover_s     = ({1'b0, col_q} < COL_COVER) && ({1'b0, row_q} < ROW_COVER);
  assign first_s     = (px_q == {PW{1'b0}}) && (py_q == {PW{1'b0}});
  assign complete_s  = cover_s && (px_q == P_LAST) && (py_q == P_LAST);
  assign last_win_s  = (row_q == ROW_WLAST) && (col_q == COL_WLAST);
  assign end_row_s   = (col_q == COL_LAST);
  assign end_frame_s = end_row_s && (row_q == ROW_LAST);

  // Per-channel accumulator update and pooled result for the current beat.
  always_comb begin
    logic [ACC_W-1:0] elem_v;
    logic [ACC_W-1:0] old_v;
    res_s = {DW{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      elem_v = ACC_W'(in_data[c*ELEM_WIDTH +: ELEM_WIDTH]);
      old_v  = acc_q[wi_s][c];
      acc_new_s[c] = elem_v;
      if (first_s) begin
        acc_new_s[c] = elem_v;
      end else begin
        case (cur_mode_s)
          MODE_MAX: acc_new_s[c] = (elem_v > old_v) ? elem_v : old_v;
          MODE_MIN: acc_new_s[c] = (elem_v < old_v) ? elem_v : old_v;
          MODE_AVG: acc_new_s[c] = old_v + elem_v;
          default:  acc_new_s[c] = elem_v;
        endcase
      end
      case (cur_mode_s)
        MODE_MAX, MODE_MIN: res_s[c*ELEM_WIDTH +: ELEM_WIDTH] = acc_new_s[c][ELEM_WIDTH-1:0];
        MODE_AVG:           res_s[c*ELEM_WIDTH +: ELEM_WIDTH] = avg_of(acc_new_s[c]);
        default:            res_s[c*ELEM_WIDTH +: ELEM_WIDTH] = {ELEM_WIDTH{1'b0}};
      endcase
    end
  end

  // Next-state for frame position, mode latch and output register.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    row_d       = row_q;
    col_d       = col_q;
    px_d        = px_q;
    py_d        = py_q;
    wc_d        = wc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (accept_s) begin
      if (state_q == ST_IDLE) begin
        mode_d = pool_mode;
      end else begin
        mode_d = mode_q;
      end
      if (end_frame_s) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_RUN;
      end
      if (end_row_s) begin
        col_d = {COL_W{1'b0}};
        px_d  = {PW{1'b0}};
        wc_d  = {WC_W{1'b0}};
        if (end_frame_s) begin
          row_d = {ROW_W{1'b0}};
          py_d  = {PW{1'b0}};
        end else begin
          row_d = row_q + ROW_W'(1);
          py_d  = (py_q == P_LAST) ? {PW{1'b0}} : py_q + PW'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
        if (px_q == P_LAST) begin
          px_d = {PW{1'b0}};
          wc_d = wc_q + WC_W'(1);
        end else begin
          px_d = px_q + PW'(1);
          wc_d = wc_q;
        end
      end
    end else begin
      state_d = state_q;
    end
    if (accept_s && complete_s) begin
      out_valid_d = 1'b1;
      out_data_d  = res_s;
      out_last_d  = last_win_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Control state and output register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= 2'd0;
      row_q       <= {ROW_W{1'b0}};
      col_q       <= {COL_W{1'b0}};
      px_q        <= {PW{1'b0}};
      py_q        <= {PW{1'b0}};
      wc_q        <= {WC_W{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {DW{1'b0}};
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      row_q       <= row_d;
      col_q       <= col_d;
      px_q        <= px_d;
      py_q        <= py_d;
      wc_q        <= wc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Accumulator bank; each entry is reloaded at its window's first element.
  always_ff @(posedge clk) begin
    if (accept_s && cover_s) begin
      acc_q[wi_s] <= acc_new_s;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule
